// File: rtl/win_pkg.sv
// Shared helpers for the sliding-window buffer.
// Contents:
//   LP_K_MIN/LP_K_MAX : legal range for the window edge length
//   k_is_legal()      : true for odd edge lengths inside that range
//   grid_lsb()        : bit offset of tap (row, col) in the packed window bus;
//                       row-major, top-left tap occupies the MSBs
package win_pkg;

   localparam int unsigned LP_K_MIN = 3;
   localparam int unsigned LP_K_MAX = 7;

   function automatic bit k_is_legal(input int unsigned k);
      return (k >= LP_K_MIN) && (k <= LP_K_MAX) && ((k % 2) == 1);
   endfunction

   function automatic int unsigned grid_lsb(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned k,
                                            input int unsigned bw);
      return ((k * k - 1) - (row * k + col)) * bw;
   endfunction

endpackage

// File: rtl/window_buffer_if.sv
// Pixel stream in / window out bundle for window_buffer.
// Signals:
//   clken   : pixel strobe                      (master -> slave)
//   sof     : start of frame, with first pixel  (master -> slave)
//   shiftin : incoming pixel, raster order      (master -> slave)
//   oGrid   : packed P_K x P_K window           (slave -> master)
//   oValid  : window/coordinates qualifier      (slave -> master)
//   oCol    : window centre column              (slave -> master)
//   oRow    : window centre row                 (slave -> master)
//   oCenter : unmasked centre pixel             (slave -> master)
interface window_buffer_if #(
   parameter int unsigned P_BIT_WIDTH  = 24,
   parameter int unsigned P_K          = 5,
   parameter int unsigned P_LINE_LEN   = 640,
   parameter int unsigned P_LINE_COUNT = 480
);
   logic                                 clken;
   logic                                 sof;
   logic [P_BIT_WIDTH-1:0]               shiftin;
   logic [P_BIT_WIDTH*P_K*P_K-1:0]       oGrid;
   logic                                 oValid;
   logic [$clog2(P_LINE_LEN)-1:0]        oCol;
   logic [$clog2(P_LINE_COUNT)-1:0]      oRow;
   logic [P_BIT_WIDTH-1:0]               oCenter;

   modport master (output clken, sof, shiftin,
                   input  oGrid, oValid, oCol, oRow, oCenter);
   modport slave  (input  clken, sof, shiftin,
                   output oGrid, oValid, oCol, oRow, oCenter);
endinterface

// File: rtl/line_delay.sv
// One image line of delay: single-port memory with a free-running address.
// The read is taken from the address about to be overwritten, so o_dout is
// the sample written exactly P_DEPTH strobes earlier. Contents are not reset.
// Ports:
//   clk     : clock
//   aclr_n  : asynchronous active-low reset (address only)
//   i_clken : advance strobe
//   i_din   : sample to store
//   o_dout  : sample stored P_DEPTH strobes ago
module line_delay #(
   parameter int unsigned P_WIDTH = 24,
   parameter int unsigned P_DEPTH = 640
) (
   input  logic               clk,
   input  logic               aclr_n,
   input  logic               i_clken,
   input  logic [P_WIDTH-1:0] i_din,
   output logic [P_WIDTH-1:0] o_dout
);
   localparam int unsigned LP_AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

   logic [P_WIDTH-1:0] r_mem [P_DEPTH];
   logic [LP_AW-1:0]   r_addr;

   assign o_dout = r_mem[r_addr];

   always_ff @(posedge clk) begin
      if (i_clken) r_mem[r_addr] <= i_din;
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_addr <= '0;
      end else if (i_clken) begin
         if (r_addr == LP_AW'(P_DEPTH - 1)) r_addr <= '0;
         else                               r_addr <= r_addr + 1'b1;
      end
   end
endmodule

// File: rtl/window_buffer.sv
// P_K x P_K sliding window over a raster pixel stream.
// P_K-1 line delays feed the rows above the incoming pixel; every accepted
// pixel shifts the window left by one column. Taps whose source lies outside
// the frame are zeroed, which also hides stale line data across frames.
// Ports:
//   clk    : clock
//   aclr_n : asynchronous active-low reset
//   bus    : window_buffer_if.slave (clken/sof/shiftin in, oGrid/oValid/
//            oCol/oRow/oCenter out, all outputs registered)
module window_buffer
   import win_pkg::*;
#(
   parameter int unsigned P_BIT_WIDTH  = 24,
   parameter int unsigned P_K          = 5,
   parameter int unsigned P_LINE_LEN   = 640,
   parameter int unsigned P_LINE_COUNT = 480
) (
   input  logic            clk,
   input  logic            aclr_n,
   window_buffer_if.slave  bus
);
   localparam int          LP_R     = int'((P_K - 1) / 2);
   localparam int          LP_W     = int'(P_LINE_LEN);
   localparam int          LP_H     = int'(P_LINE_COUNT);
   localparam int unsigned LP_CW    = $clog2(P_LINE_LEN);
   localparam int unsigned LP_RW    = $clog2(P_LINE_COUNT);
   localparam int unsigned LP_PRIME = ((P_K - 1) / 2) * P_LINE_LEN + (P_K - 1) / 2;
   localparam int unsigned LP_PW    = $clog2(LP_PRIME + 1);
   localparam int unsigned LP_GW    = P_BIT_WIDTH * P_K * P_K;

   if (!k_is_legal(P_K)) begin : g_bad_k
      $error("window_buffer: P_K must be odd and within 3..7");
   end

   logic [P_BIT_WIDTH-1:0] w_ld     [P_K-1];
   logic [P_BIT_WIDTH-1:0] w_tap    [P_K];
   logic [P_BIT_WIDTH-1:0] w_win_nx [P_K][P_K];
   logic [P_BIT_WIDTH-1:0] r_win    [P_K][P_K];
   logic [LP_GW-1:0]       w_grid_nx;
   logic [LP_CW-1:0]       w_cin, w_icol_nx, w_ccol, r_icol, r_ocol;
   logic [LP_RW-1:0]       w_rin, w_irow_nx, w_crow, r_irow, r_orow;
   logic [LP_PW-1:0]       r_pcnt;
   logic                   w_primed;
   logic                   r_valid;
   logic [P_BIT_WIDTH-1:0] r_ocenter;
   logic [LP_GW-1:0]       r_grid;

   // Bottom window row is the live pixel; row P_K-2-j comes from delay j.
   assign w_tap[P_K-1] = bus.shiftin;

   for (genvar j = 0; j < P_K - 1; j++) begin : g_line
      logic [P_BIT_WIDTH-1:0] w_din;
      if (j == 0) begin : g_first
         assign w_din = bus.shiftin;
      end else begin : g_next
         assign w_din = w_ld[j-1];
      end
      line_delay #(.P_WIDTH(P_BIT_WIDTH), .P_DEPTH(P_LINE_LEN)) u_line (
         .clk     (clk),
         .aclr_n  (aclr_n),
         .i_clken (bus.clken),
         .i_din   (w_din),
         .o_dout  (w_ld[j])
      );
      assign w_tap[P_K-2-j] = w_ld[j];
   end

   assign w_primed = (r_pcnt == LP_PW'(LP_PRIME));

   // Position of the pixel being accepted; sof forces it to the frame origin.
   always_comb begin
      w_cin     = bus.sof ? '0 : r_icol;
      w_rin     = bus.sof ? '0 : r_irow;
      w_icol_nx = w_cin + 1'b1;
      w_irow_nx = w_rin;
      if (w_cin == LP_CW'(P_LINE_LEN - 1)) begin
         w_icol_nx = '0;
         w_irow_nx = (w_rin == LP_RW'(P_LINE_COUNT - 1)) ? '0 : w_rin + 1'b1;
      end
   end

   // Centre lags the incoming pixel by R rows and R columns; borrows wrap
   // into the previous row / previous frame. The window is masked against
   // that centre before being registered.
   always_comb begin
      int v_c, v_r, v_sc, v_sr;
      v_c  = int'(w_cin) - LP_R;
      v_r  = int'(w_rin);
      v_sc = 0;
      v_sr = 0;
      if (v_c < 0) begin
         v_c = v_c + LP_W;
         v_r = v_r - 1;
      end
      v_r = v_r - LP_R;
      if (v_r < 0) v_r = v_r + LP_H;
      w_ccol    = LP_CW'(v_c);
      w_crow    = LP_RW'(v_r);
      w_grid_nx = '0;
      for (int unsigned r = 0; r < P_K; r++) begin
         for (int unsigned c = 0; c < P_K; c++) begin
            w_win_nx[r][c] = (c == P_K - 1) ? w_tap[r] : r_win[r][c+1];
            v_sr = v_r + int'(r) - LP_R;
            v_sc = v_c + int'(c) - LP_R;
            if (v_sr >= 0 && v_sr < LP_H && v_sc >= 0 && v_sc < LP_W)
               w_grid_nx[grid_lsb(r, c, P_K, P_BIT_WIDTH) +: P_BIT_WIDTH] = w_win_nx[r][c];
         end
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_icol    <= '0;
         r_irow    <= '0;
         r_pcnt    <= '0;
         r_valid   <= 1'b0;
         r_ocol    <= '0;
         r_orow    <= '0;
         r_ocenter <= '0;
         r_grid    <= '0;
         for (int unsigned r = 0; r < P_K; r++)
            for (int unsigned c = 0; c < P_K; c++)
               r_win[r][c] <= '0;
      end else begin
         r_valid <= bus.clken && w_primed;
         if (bus.clken) begin
            r_icol    <= w_icol_nx;
            r_irow    <= w_irow_nx;
            if (!w_primed) r_pcnt <= r_pcnt + 1'b1;
            r_ocol    <= w_ccol;
            r_orow    <= w_crow;
            r_ocenter <= w_win_nx[LP_R][LP_R];
            r_grid    <= w_grid_nx;
            for (int unsigned r = 0; r < P_K; r++)
               for (int unsigned c = 0; c < P_K; c++)
                  r_win[r][c] <= w_win_nx[r][c];
         end
      end
   end

   assign bus.oGrid   = r_grid;
   assign bus.oValid  = r_valid;
   assign bus.oCol    = r_ocol;
   assign bus.oRow    = r_orow;
   assign bus.oCenter = r_ocenter;
endmodule
